// File: rtl/mosaic_pkg.sv
// Shared types and default widths for the mosaic coordinate generator.
// Optional build macro used by the design: MOSAIC_SHADOW_EN.
package mosaic_pkg;

    localparam int DEF_NUM_CH  = 2;
    localparam int DEF_COORD_W = 10;
    localparam int DEF_SCALE_W = 4;

    typedef logic [DEF_COORD_W-1:0] coord_t;
    typedef logic [DEF_SCALE_W-1:0] scale_t;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } mosaic_state_t;

endpackage

// File: rtl/mosaic_coord_gen_if.sv
// Scan-in / coordinate-out bundle of the mosaic coordinate generator.
// Handshake: no backpressure. A pixel is presented when pix_valid=1 and is
// consumed in that same cycle; frame_start/line_start/row/col are only
// meaningful while pix_valid=1. out_valid=1 marks x/y as the result of the
// pixel accepted one cycle earlier; x/y hold their value while out_valid=0.
interface mosaic_coord_gen_if
    import mosaic_pkg::*;
#(
    parameter int NUM_CH  = DEF_NUM_CH,
    parameter int COORD_W = DEF_COORD_W
);
    logic                      frame_start;
    logic                      line_start;
    logic                      pix_valid;
    logic [COORD_W-1:0]        row;
    logic [COORD_W-1:0]        col;
    logic                      out_valid;
    logic [NUM_CH*COORD_W-1:0] x;
    logic [NUM_CH*COORD_W-1:0] y;

    modport master (
        output frame_start, line_start, pix_valid, row, col,
        input  out_valid, x, y
    );

    modport slave (
        input  frame_start, line_start, pix_valid, row, col,
        output out_valid, x, y
    );
endinterface

// File: rtl/mosaic_axis_counter.sv
// One axis of one mosaic channel: tracks the phase inside the current block
// and holds the block's first coordinate (the snapped value).
module mosaic_axis_counter
    import mosaic_pkg::*;
#(
    parameter int COORD_W = DEF_COORD_W,
    parameter int SCALE_W = DEF_SCALE_W
) (
    input  logic               clock,
    input  logic               reset_N,
    input  logic               advance,
    input  logic               restart,
    input  logic [SCALE_W-1:0] size,
    input  logic [COORD_W-1:0] coord,
    output logic [COORD_W-1:0] base,
    output logic [SCALE_W-1:0] cnt
);

    // Open a new block on restart or once the phase reaches the size; the >=
    // keeps a freshly shrunk size from letting the counter run past it.
    always_ff @(posedge clock or negedge reset_N) begin
        if (!reset_N) begin
            base <= '0;
            cnt  <= '0;
        end else if (advance) begin
            if (restart || (cnt >= size)) begin
                base <= coord;
                cnt  <= '0;
            end else begin
                cnt  <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/mosaic_coord_gen.sv
// Multi-channel mosaic coordinate generator: snaps the scan position to the
// top-left of its mosaic block per channel, one cycle after the pixel.
// Build macro MOSAIC_SHADOW_EN: sizes are sampled at line/frame start instead
// of being used live.
module mosaic_coord_gen
    import mosaic_pkg::*;
#(
    parameter int NUM_CH  = DEF_NUM_CH,
    parameter int COORD_W = DEF_COORD_W,
    parameter int SCALE_W = DEF_SCALE_W
) (
    input  logic                      clock,
    input  logic                      reset_N,
    mosaic_coord_gen_if.slave         bus,
    input  logic [NUM_CH-1:0]         mosaic,
    input  logic [NUM_CH*SCALE_W-1:0] hscale,
    input  logic [NUM_CH*SCALE_W-1:0] vscale,
    output mosaic_state_t             state,
    output logic [NUM_CH*SCALE_W-1:0] hphase,
    output logic [NUM_CH*SCALE_W-1:0] vphase
);

    mosaic_state_t state_q, state_d;
    logic          accept;
    logic          line_eff;
    logic          out_valid_q;

    logic [COORD_W-1:0] xbase [NUM_CH];
    logic [COORD_W-1:0] ybase [NUM_CH];
    logic [SCALE_W-1:0] hcnt  [NUM_CH];
    logic [SCALE_W-1:0] vcnt  [NUM_CH];

    // State register.
    always_ff @(posedge clock or negedge reset_N) begin
        if (!reset_N) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // Next state: a valid frame_start pixel starts tracking; stay active after.
    always_comb begin
        state_d = state_q;
        if (state_q == IDLE && bus.pix_valid && bus.frame_start) state_d = ACTIVE;
    end

    // FSM outputs: which pixels are accepted, and frame start doubling as line start.
    always_comb begin
        accept   = bus.pix_valid && ((state_q == ACTIVE) || bus.frame_start);
        line_eff = bus.line_start || bus.frame_start;
    end

    // Output valid is the accepted flag delayed by one cycle.
    always_ff @(posedge clock or negedge reset_N) begin
        if (!reset_N) out_valid_q <= 1'b0;
        else          out_valid_q <= accept;
    end

    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
        logic [SCALE_W-1:0] hs_live, vs_live, hs_use, vs_use;

        assign hs_live = mosaic[ch] ? hscale[ch*SCALE_W +: SCALE_W] : '0;
        assign vs_live = mosaic[ch] ? vscale[ch*SCALE_W +: SCALE_W] : '0;

`ifdef MOSAIC_SHADOW_EN
        logic [SCALE_W-1:0] hs_shadow, vs_shadow;

        // Capture sizes at line/frame start so mid-line writes wait for the next one.
        always_ff @(posedge clock or negedge reset_N) begin
            if (!reset_N) begin
                hs_shadow <= '0;
                vs_shadow <= '0;
            end else begin
                if (accept && line_eff)        hs_shadow <= hs_live;
                if (accept && bus.frame_start) vs_shadow <= vs_live;
            end
        end

        assign hs_use = (accept && line_eff)        ? hs_live : hs_shadow;
        assign vs_use = (accept && bus.frame_start) ? vs_live : vs_shadow;
`else
        assign hs_use = hs_live;
        assign vs_use = vs_live;
`endif

        mosaic_axis_counter #(.COORD_W(COORD_W), .SCALE_W(SCALE_W)) u_h (
            .clock   (clock),
            .reset_N (reset_N),
            .advance (accept),
            .restart (line_eff),
            .size    (hs_use),
            .coord   (bus.col),
            .base    (xbase[ch]),
            .cnt     (hcnt[ch])
        );

        mosaic_axis_counter #(.COORD_W(COORD_W), .SCALE_W(SCALE_W)) u_v (
            .clock   (clock),
            .reset_N (reset_N),
            .advance (accept && line_eff),
            .restart (bus.frame_start),
            .size    (vs_use),
            .coord   (bus.row),
            .base    (ybase[ch]),
            .cnt     (vcnt[ch])
        );
    end

    // Pack per-channel bases and phases onto the flat output buses.
    always_comb begin
        bus.x  = '0;
        bus.y  = '0;
        hphase = '0;
        vphase = '0;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            bus.x[ch*COORD_W +: COORD_W]  = xbase[ch];
            bus.y[ch*COORD_W +: COORD_W]  = ybase[ch];
            hphase[ch*SCALE_W +: SCALE_W] = hcnt[ch];
            vphase[ch*SCALE_W +: SCALE_W] = vcnt[ch];
        end
    end

    assign bus.out_valid = out_valid_q;
    assign state         = state_q;

endmodule
